// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
// Pointer wrap and counter sizing are done here so the arbitrary-depth logic stays in one place.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_flags_t;

  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-2 depths never reach unused slots.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_sync_prog: one write port and one registered read port.
// The array itself is never reset; only the read register is.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with arbitrary depth, occupancy count, programmable thresholds and flush.
// Define FIFO_PARITY_EN to store an even-parity bit per entry and flag read-side mismatches.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = calc_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  input  logic [CNT_W-1:0]      af_level,
  input  logic [CNT_W-1:0]      ae_level,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  parity_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef FIFO_PARITY_EN
  localparam int MEM_W = FIFO_WIDTH + 1;
`else
  localparam int MEM_W = FIFO_WIDTH;
`endif

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ack_q, wr_ack_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [MEM_W-1:0] wr_word, rd_word;
  fifo_flags_t      flags;

  assign flags.full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign flags.empty       = (count_q == '0);
  assign flags.almostfull  = (count_q >= af_level);
  assign flags.almostempty = (count_q <= ae_level);

  // Flush masks both requests; a read when full frees the slot for a same-cycle write.
  assign wr_acc = !flush && wr_en && (!flags.full || rd_en);
  assign rd_acc = !flush && rd_en && !flags.empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_acc;
    overflow_d  = !flush && wr_en && flags.full && !rd_en;
    underflow_d = !flush && rd_en && flags.empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), FIFO_DEPTH));
      if (rd_acc) rd_ptr_d = PTR_W'(next_ptr(32'(rd_ptr_q), FIFO_DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_PARITY_EN
  assign wr_word    = {^data_in, data_in};
  // Stored bit makes the whole word even; any odd result is a corrupted entry.
  assign parity_err = ^rd_word;
`else
  assign wr_word    = data_in;
  assign parity_err = 1'b0;
`endif

  fifo_mem #(
    .WIDTH (MEM_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_word)
  );

  assign data_out    = rd_word[FIFO_WIDTH-1:0];
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign count       = count_q;
  assign full        = flags.full;
  assign empty       = flags.empty;
  assign almostfull  = flags.almostfull;
  assign almostempty = flags.almostempty;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Directed bench for fifo_sync_prog: depth-8 instance for the main sequence, depth-5 for wrap.
module tb_fifo_sync_prog;

  logic        clk = 1'b0;
  logic        rst;

  logic        flush, wr_en, rd_en;
  logic [15:0] data_in, data_out;
  logic        wr_ack, overflow, underflow;
  logic [3:0]  af_level, ae_level, count;
  logic        full, empty, almostfull, almostempty, parity_err;

  logic        flush5, wr_en5, rd_en5;
  logic [15:0] data_in5, data_out5;
  logic        wr_ack5, overflow5, underflow5;
  logic [2:0]  af_level5, ae_level5, count5;
  logic        full5, empty5, almostfull5, almostempty5, parity_err5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .af_level(af_level), .ae_level(ae_level), .count(count),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .parity_err(parity_err)
  );

  fifo_sync_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .flush(flush5), .wr_en(wr_en5), .data_in(data_in5),
    .rd_en(rd_en5), .data_out(data_out5), .wr_ack(wr_ack5), .overflow(overflow5),
    .underflow(underflow5), .af_level(af_level5), .ae_level(ae_level5), .count(count5),
    .full(full5), .empty(empty5), .almostfull(almostfull5), .almostempty(almostempty5),
    .parity_err(parity_err5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; wr_en = 0; rd_en = 0; data_in = '0; af_level = 4'd6; ae_level = 4'd2;
    flush5 = 0; wr_en5 = 0; rd_en5 = 0; data_in5 = '0; af_level5 = 3'd4; ae_level5 = 3'd1;
    #12;
    rst = 1'b0;

    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_data_out", data_out, 0);
    check("rst_pulses", {wr_ack, overflow, underflow}, 0);
    check("rst_parity_err", parity_err, 0);

    // Fill to full, watching thresholds 6 / 2
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1; data_in = 16'(i);
      tick();
      check($sformatf("fill_ack_%0d", i), wr_ack, 1);
      check($sformatf("fill_count_%0d", i), count, i);
      check($sformatf("fill_af_%0d", i), almostfull, (i >= 6) ? 1 : 0);
      check($sformatf("fill_ae_%0d", i), almostempty, (i <= 2) ? 1 : 0);
    end
    check("fill_full", full, 1);

    data_in = 16'h0009;
    tick();
    check("ovf_pulse", overflow, 1);
    check("ovf_ack", wr_ack, 0);
    check("ovf_count", count, 8);
    wr_en = 0;
    tick();
    check("ovf_clear", overflow, 0);

    // Simultaneous read+write while full
    wr_en = 1; rd_en = 1; data_in = 16'h00AA;
    tick();
    check("full_rw_count", count, 8);
    check("full_rw_ovf", overflow, 0);
    check("full_rw_data", data_out, 16'h0001);
    check("full_rw_ack", wr_ack, 1);

    // Drain: 2..8 then 0xAA
    wr_en = 0; rd_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("drain_data_%0d", i), data_out, (i < 7) ? 32'(i + 2) : 32'h00AA);
      check($sformatf("drain_count_%0d", i), count, 7 - i);
    end
    check("drain_empty", empty, 1);
    tick();
    check("udf_pulse", underflow, 1);
    check("udf_data_hold", data_out, 16'h00AA);
    rd_en = 0;
    tick();
    check("udf_clear", underflow, 0);
    check("idle_data_hold", data_out, 16'h00AA);

    // Simultaneous read+write while empty: no fall-through
    wr_en = 1; rd_en = 1; data_in = 16'h0055;
    tick();
    check("empty_rw_udf", underflow, 1);
    check("empty_rw_count", count, 1);
    check("empty_rw_data", data_out, 16'h00AA);
    wr_en = 0;
    tick();
    check("empty_rw_read", data_out, 16'h0055);
    check("empty_rw_count2", count, 0);
    rd_en = 0;

    // Threshold change takes effect combinationally
    wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      data_in = 16'(16'h0010 + i);
      tick();
    end
    wr_en = 0;
    check("thr_count4", count, 4);
    check("thr_af_before", almostfull, 0);
    af_level = 4'd3;
    #1;
    check("thr_af_after", almostfull, 1);
    af_level = 4'd6;
    wr_en = 1; data_in = 16'h0014;
    tick();
    check("thr_count5", count, 5);

    // Flush beats a write in the same cycle
    flush = 1; data_in = 16'h0099;
    tick();
    flush = 0; wr_en = 0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ack", wr_ack, 0);
    check("flush_data_hold", data_out, 16'h0055);
    af_level = 4'd0;
    #1;
    check("af_zero", almostfull, 1);
    af_level = 4'd6;

    wr_en = 1; data_in = 16'h0077;
    tick();
    wr_en = 0; rd_en = 1;
    tick();
    rd_en = 0;
    check("post_flush_data", data_out, 16'h0077);

    // Reset in the middle of a burst
    wr_en = 1; data_in = 16'h0031;
    tick();
    data_in = 16'h0032;
    tick();
    rd_en = 1; data_in = 16'h0033;
    tick();
    check("burst_data", data_out, 16'h0031);
    check("burst_ack", wr_ack, 1);
    #2;
    rst = 1;
    #1;
    check("midrst_data", data_out, 0);
    check("midrst_ack", wr_ack, 0);
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    wr_en = 0; rd_en = 0;
    #2;
    rst = 0;
    rd_en = 1;
    tick();
    rd_en = 0;
    check("postrst_udf", underflow, 1);
    check("postrst_data", data_out, 0);

    // Depth 5: prefill two, then 12 paired write/read through the wrap
    wr_en5 = 1; data_in5 = 16'h00A0;
    tick();
    data_in5 = 16'h00A1;
    tick();
    rd_en5 = 1;
    for (int k = 0; k < 12; k++) begin
      data_in5 = 16'(16'h00B0 + k);
      tick();
      check($sformatf("d5_data_%0d", k), data_out5,
            (k == 0) ? 32'h00A0 : (k == 1) ? 32'h00A1 : 32'(16'h00B0 + k - 2));
      check($sformatf("d5_count_%0d", k), count5, 2);
    end
    rd_en5 = 0;
    for (int k = 0; k < 3; k++) begin
      data_in5 = 16'(16'h00C0 + k);
      tick();
    end
    check("d5_count_full", count5, 5);
    check("d5_full", full5, 1);
    tick();
    check("d5_ovf", overflow5, 1);
    check("d5_count_hold", count5, 5);
    wr_en5 = 0; rd_en5 = 1;
    tick();
    rd_en5 = 0;
    check("d5_oldest", data_out5, 16'h00BA);
    check("d5_count4", count5, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
